led_blink_ctrl: RTL and testbench

//   Multi-channel, runtime-configurable LED/status counter. Generalises the single fixed-period

---
 rtl/led_blink_ctrl_pkg.sv | 17 +
 rtl/led_blink_ctrl_chan.sv | 93 +++++++++
 rtl/led_blink_ctrl.sv | 44 ++++
 tb/tb_led_blink_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_ctrl_pkg.sv
// Shared mode encodings and helpers for the multi-channel LED blink controller.
// Mode values match the 2-bit cfg_mode field written by the CSR logic.
package led_blink_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_ON      = 2'd1,
    LED_MODE_BLINK   = 2'd2,
    LED_MODE_ONESHOT = 2'd3
  } led_mode_e;

  // LED level a channel takes on the edge a new mode is loaded.
  function automatic logic led_on_load(input led_mode_e m);
    return (m == LED_MODE_ON) || (m == LED_MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/led_blink_ctrl_chan.sv
// One LED channel: period counter, mode, registered LED level and wrap/done strobes.
// Config write takes effect on the next edge and overrides a same-cycle terminal count.
module led_chan
  import led_blink_ctrl_pkg::*;
#(
  parameter int              CNT_W    = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(24_999_999),
  parameter logic [1:0]      RST_MODE = 2'd2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_mode,
  input  logic [CNT_W-1:0] wr_max,
  output logic             led,
  output logic             wrap,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] max_q, max_d;
  led_mode_e        mode_q, mode_d;
  logic             led_d, wrap_d, done_d;
  logic             at_term;

  assign at_term = (cnt_q == max_q);

  always_comb begin
    cnt_d  = cnt_q;
    max_d  = max_q;
    mode_d = mode_q;
    led_d  = led;
    wrap_d = 1'b0;
    done_d = 1'b0;
    if (wr_en) begin
      // A write discards any terminal count landing on the same edge.
      mode_d = led_mode_e'(wr_mode);
      max_d  = wr_max;
      cnt_d  = '0;
      led_d  = led_on_load(led_mode_e'(wr_mode));
    end else begin
      unique case (mode_q)
        LED_MODE_OFF: begin
          cnt_d = '0;
          led_d = 1'b0;
        end
        LED_MODE_ON: begin
          cnt_d = '0;
          led_d = 1'b1;
        end
        LED_MODE_BLINK: begin
          if (at_term) begin
            cnt_d  = '0;
            led_d  = ~led;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LED_MODE_ONESHOT: begin
          if (at_term) begin
            cnt_d  = '0;
            led_d  = 1'b0;
            mode_d = LED_MODE_OFF;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            led_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      max_q  <= CNT_MAX;
      mode_q <= led_mode_e'(RST_MODE);
      led    <= 1'b0;
      wrap   <= 1'b0;
      done   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      max_q  <= max_d;
      mode_q <= mode_d;
      led    <= led_d;
      wrap   <= wrap_d;
      done   <= done_d;
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// NUM_CH independent LED channels; cfg writes are decoded to one channel and never stall.
// Out-of-range cfg_ch matches no channel, so such writes are dropped.
module led_blink_ctrl
  import led_blink_ctrl_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  parameter int               CNT_W    = 25,
  parameter logic [CNT_W-1:0] CNT_MAX  = CNT_W'(24_999_999),
  parameter logic [1:0]       RST_MODE = 2'd2,
  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_max,
  output logic [NUM_CH-1:0] led_out,
  output logic [NUM_CH-1:0] wrap_pulse,
  output logic [NUM_CH-1:0] done_pulse
);

  logic [NUM_CH-1:0] wr_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = cfg_valid && (cfg_ch == CH_W'(i));

    led_chan #(
      .CNT_W   (CNT_W),
      .CNT_MAX (CNT_MAX),
      .RST_MODE(RST_MODE)
    ) u_chan (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .wr_en  (wr_en[i]),
      .wr_mode(cfg_mode),
      .wr_max (cfg_max),
      .led    (led_out[i]),
      .wrap   (wrap_pulse[i]),
      .done   (done_pulse[i])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Randomized bench for led_blink_ctrl with an event-time reference model and literal pin checks.
module tb_led_blink_ctrl;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 25;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_max = '0;
  logic [NUM_CH-1:0] led_out, wrap_pulse, done_pulse;

  int checks = 0;
  int failures = 0;

  always #10 sys_clk = ~sys_clk;

  led_blink_ctrl #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .CNT_MAX (25'd24),
    .RST_MODE(2'd2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_max   (cfg_max),
    .led_out   (led_out),
    .wrap_pulse(wrap_pulse),
    .done_pulse(done_pulse)
  );

  // Model: each channel remembers the edge its current mode started and its period;
  // outputs follow from the number of edges elapsed since then.
  longint cyc = 0;
  longint t0[NUM_CH];
  longint per[NUM_CH];
  int     md[NUM_CH];
  bit     model_live = 1'b0;

  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (sys_rst) begin
      model_live = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        md[c] = 2; per[c] = 24; t0[c] = cyc;
      end
    end else if (cfg_valid && cfg_ch < NUM_CH) begin
      md[cfg_ch]  = int'(cfg_mode);
      per[cfg_ch] = longint'(cfg_max);
      t0[cfg_ch]  = cyc;
    end
  end

  function automatic void model_ch(input int c, output bit l, output bit w, output bit d);
    longint k, p1;
    k  = cyc - t0[c];
    p1 = per[c] + 1;
    l = 1'b0; w = 1'b0; d = 1'b0;
    case (md[c])
      1: l = 1'b1;
      2: begin
        l = ((k / p1) % 2) == 1;
        w = (k > 0) && ((k % p1) == 0);
      end
      3: begin
        l = (k < p1);
        d = (k == p1);
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (model_live) begin
      logic [NUM_CH-1:0] el, ew, ed;
      for (int c = 0; c < NUM_CH; c++) begin
        bit l, w, d;
        model_ch(c, l, w, d);
        el[c] = l; ew[c] = w; ed[c] = d;
      end
      check("model_led_out", 32'(led_out), 32'(el));
      check("model_wrap_pulse", 32'(wrap_pulse), 32'(ew));
      check("model_done_pulse", 32'(done_pulse), 32'(ed));
    end
  end

  task automatic cfg_write(input int ch, input int mode, input int mx);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_max   = CNT_W'(mx);
    @(posedge sys_clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int hi, dn, wr;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // Default blink: 25 edges per toggle after release.
    repeat (24) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_blink_k24_led", 32'(led_out), 32'h0);
    check("rst_blink_k24_wrap", 32'(wrap_pulse), 32'h0);
    @(posedge sys_clk); @(negedge sys_clk);
    check("rst_blink_k25_led", 32'(led_out), 32'h7);
    check("rst_blink_k25_wrap", 32'(wrap_pulse), 32'h7);
    repeat (25) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_blink_k50_led", 32'(led_out), 32'h0);
    check("rst_blink_k50_wrap", 32'(wrap_pulse), 32'h7);
    @(posedge sys_clk); #1;

    // ch1 short blink mid-count.
    idle(7);
    cfg_write(1, 2, 3);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("ch1_max3_k3_wrap", 32'(wrap_pulse[1]), 32'h0);
    @(posedge sys_clk); @(negedge sys_clk);
    check("ch1_max3_k4_wrap", 32'(wrap_pulse[1]), 32'h1);
    check("ch1_max3_k4_led", 32'(led_out[1]), 32'h1);
    @(posedge sys_clk); #1;

    // ch2 oneshot max=9.
    cfg_write(2, 3, 9);
    hi = 0; dn = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk);
      if (led_out[2]) hi++;
      if (done_pulse[2]) begin
        dn++;
        check("ch2_done_with_led_low", 32'(led_out[2]), 32'h0);
      end
    end
    check("ch2_oneshot_high_cycles", 32'(hi), 32'd10);
    check("ch2_oneshot_done_count", 32'(dn), 32'd1);
    @(posedge sys_clk); #1;

    // ch0 max=0 blink then oneshot.
    cfg_write(0, 2, 0);
    hi = 0; wr = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      if (led_out[0] == 1'(i % 2 == 0)) hi++;
      if (wrap_pulse[0]) wr++;
    end
    check("ch0_max0_toggle_every_cycle", 32'(hi), 32'd6);
    check("ch0_max0_wrap_held", 32'(wr), 32'd6);
    @(posedge sys_clk); #1;
    cfg_write(0, 3, 0);
    hi = 0; dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      if (led_out[0]) hi++;
      if (done_pulse[0]) dn++;
      @(posedge sys_clk);
    end
    #1;
    check("ch0_oneshot0_high", 32'(hi), 32'd1);
    check("ch0_oneshot0_done", 32'(dn), 32'd1);

    // Write ch1 exactly on its terminal-count edge.
    while (((cyc + 1 - t0[1]) % 4) != 0) begin
      @(posedge sys_clk); #1;
    end
    cfg_write(1, 2, 5);
    @(negedge sys_clk);
    check("ch1_term_write_no_wrap", 32'(wrap_pulse[1]), 32'h0);
    check("ch1_term_write_led", 32'(led_out[1]), 32'h0);
    repeat (6) @(posedge sys_clk);
    @(negedge sys_clk);
    check("ch1_new_period_wrap", 32'(wrap_pulse[1]), 32'h1);
    @(posedge sys_clk); #1;

    // Reset in the middle of a oneshot, then an out-of-range write.
    cfg_write(2, 3, 20);
    idle(5);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("mid_oneshot_rst_led", 32'(led_out), 32'h0);
    check("mid_oneshot_rst_pulses", 32'({wrap_pulse, done_pulse}), 32'h0);
    @(posedge sys_clk); #1;
    cfg_write(3, 1, 5);
    @(negedge sys_clk);
    check("oob_write_ignored", 32'(led_out), 32'h0);
    @(posedge sys_clk); #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 25) begin
        cfg_write($urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 8));
      end else if (r == 99) begin
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
      end else begin
        idle(1);
      end
    end

    @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
